// File: rtl/mem_req_initiator.sv
// Synchronous bus master for an asynchronous 4-phase req/ack memory port.
// Sequences address/data/write strobe/req and returns one registered response per command.
module mem_req_initiator #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_req,
    input  logic                  mem_ack
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] WSTB  = 3'd2;
    localparam logic [2:0] REQ   = 3'd3;
    localparam logic [2:0] REL   = 3'd4;
    localparam logic [2:0] RESP  = 3'd5;

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // mem_ack is fully asynchronous to clk; only ack_s is used by the FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mem_ack};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        mem_write_d = mem_write_q;
        mem_req_d   = mem_req_q;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        wdata_d     = wdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = SETUP;
                    wr_d        = cmd_write;
                    waddr_d     = cmd_addr;
                    raddr_d     = cmd_addr;
                    wdata_d     = cmd_wdata;
                    mem_write_d = 1'b0;
                    mem_req_d   = 1'b0;
                end
            end
            SETUP: begin
                if (wr_q) begin
                    state_d     = WSTB;
                    mem_write_d = 1'b1;
                end else begin
                    state_d   = REQ;
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            WSTB: begin
                state_d   = REQ;
                mem_req_d = 1'b1;
                cnt_d     = '0;
            end
            REQ: begin
                // ack is tested before the timeout so a late-but-in-time ack still succeeds
                if (ack_s) begin
                    state_d     = REL;
                    mem_req_d   = 1'b0;
                    cnt_d       = '0;
                    rsp_rdata_d = wr_q ? '0 : mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REL: begin
                if (!ack_s) begin
                    state_d     = RESP;
                    mem_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stuck-high ack after an abort must fall before a new handshake may start
        cmd_ready_d = (state_d == IDLE) && !ack_s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_req_q   <= 1'b0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            mem_write_q <= mem_write_d;
            mem_req_q   <= mem_req_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_rdata         = rsp_rdata_q;
    assign rsp_error         = rsp_error_q;
    assign mem_write         = mem_write_q;
    assign mem_req           = mem_req_q;
    assign mem_write_address = waddr_q;
    assign mem_read_address  = raddr_q;
    assign mem_wdata         = wdata_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Bench for mem_req_initiator: RAM model with ack following req (overridable),
// expected responses queued at issue time and compared when rsp_valid appears.
module tb_mem_req_initiator;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int S  = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          cmd_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          mem_write;
    logic [AW-1:0] mem_write_address;
    logic [AW-1:0] mem_read_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_req;
    logic          mem_ack;

    logic stuck_hi = 1'b0;
    logic stuck_lo = 1'b0;
    logic [DW-1:0] ram [256];

    mem_req_initiator #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(S), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_write(mem_write), .mem_write_address(mem_write_address),
        .mem_read_address(mem_read_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_ack(mem_ack)
    );

    assign mem_ack   = stuck_hi ? 1'b1 : (stuck_lo ? 1'b0 : mem_req);
    assign mem_rdata = ram[mem_read_address];
    always @(posedge mem_write) ram[mem_write_address] = mem_wdata;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge bookkeeping on the falling edge: cyc then names the edge that produced the value
    logic mw_prev = 1'b0, mr_prev = 1'b0, mw_seen = 1'b0;
    int   mw_rise = -1, mr_rise = -1, mreq_cnt = 0;
    always @(negedge clk) begin
        if (mem_write && !mw_prev) mw_rise = cyc;
        if (mem_req && !mr_prev) mr_rise = cyc;
        if (mem_req) mreq_cnt = mreq_cnt + 1;
        if (mem_write) mw_seen = 1'b1;
        mw_prev = mem_write;
        mr_prev = mem_req;
    end

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            due;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Called at a sample point; returns the accept edge number or -1 if cmd_ready never came
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int acc);
        acc = -1;
        for (int k = 0; k < 40 && cmd_ready !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        if (cmd_ready === 1'b1) begin
            cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
            @(posedge clk); #1;
            acc = cyc;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int lim, output logic got, output int at,
                            output logic [DW-1:0] rd, output logic er);
        got = 1'b0; at = -1; rd = '0; er = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin
                got = 1'b1; at = cyc; rd = rsp_rdata; er = rsp_error;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_error, mem_req, mem_write} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {cmd_ready, rsp_valid, rsp_error, mem_req, mem_write});
        end
        n_cmp++;
        if ({mem_write_address, mem_read_address, mem_wdata, rsp_rdata} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0",
                     {mem_write_address, mem_read_address, mem_wdata, rsp_rdata});
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_read();
        int acc, at; logic got, er; logic [DW-1:0] rd; exp_t e;
        mw_seen = 1'b0;
        issue(1'b0, 8'h12, 8'h00, acc);
        n_cmp++;
        if (acc < 0) begin n_bad++; $display("FAIL read_accept: got none want accept"); return; end
        sb.push_back('{ram[8'h12], 1'b0, acc + 2*S + 3});
        wait_rsp(40, got, at, rd, er);
        e = sb.pop_front();
        n_cmp++;
        if (at !== e.due) begin n_bad++; $display("FAIL read_time: got %0d want %0d", at, e.due); end
        n_cmp++;
        if (rd !== e.rdata || er !== e.err) begin
            n_bad++; $display("FAIL read_data: got %h/%b want %h/%b", rd, er, e.rdata, e.err);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL read_pulse: got %b want 0", rsp_valid); end
        n_cmp++;
        if (mw_seen !== 1'b0) begin n_bad++; $display("FAIL read_nowrite: got %b want 0", mw_seen); end
    endtask

    task automatic test_write_read();
        int acc, at; logic got, er; logic [DW-1:0] rd; exp_t e;
        mw_rise = -1; mr_rise = -1;
        issue(1'b1, 8'h07, 8'h3C, acc);
        n_cmp++;
        if (acc < 0) begin n_bad++; $display("FAIL wr_accept: got none want accept"); return; end
        sb.push_back('{8'h00, 1'b0, acc + 2*S + 4});
        wait_rsp(40, got, at, rd, er);
        e = sb.pop_front();
        n_cmp++;
        if (at !== e.due) begin n_bad++; $display("FAIL wr_time: got %0d want %0d", at, e.due); end
        n_cmp++;
        if (rd !== e.rdata || er !== e.err) begin
            n_bad++; $display("FAIL wr_rsp: got %h/%b want %h/%b", rd, er, e.rdata, e.err);
        end
        n_cmp++;
        if (mw_rise !== acc + 1 || mr_rise !== acc + 2) begin
            n_bad++;
            $display("FAIL wr_strobe_order: got write@%0d req@%0d want write@%0d req@%0d",
                     mw_rise, mr_rise, acc + 1, acc + 2);
        end
        n_cmp++;
        if (ram[8'h07] !== 8'h3C) begin n_bad++; $display("FAIL wr_commit: got %h want 3c", ram[8'h07]); end
        issue(1'b0, 8'h07, 8'h00, acc);
        sb.push_back('{8'h3C, 1'b0, acc + 2*S + 3});
        wait_rsp(40, got, at, rd, er);
        e = sb.pop_front();
        n_cmp++;
        if (at !== e.due || rd !== e.rdata || er !== e.err) begin
            n_bad++;
            $display("FAIL wr_readback: got @%0d %h/%b want @%0d %h/%b", at, rd, er, e.due, e.rdata, e.err);
        end
    endtask

    task automatic test_timeout_low();
        int acc, at; logic got, er; logic [DW-1:0] rd; exp_t e;
        stuck_lo = 1'b1;
        issue(1'b0, 8'h33, 8'h00, acc);
        mreq_cnt = 0;
        sb.push_back('{8'h00, 1'b1, acc + TO + 1});
        wait_rsp(60, got, at, rd, er);
        e = sb.pop_front();
        n_cmp++;
        if (at !== e.due) begin n_bad++; $display("FAIL tmo_time: got %0d want %0d", at, e.due); end
        n_cmp++;
        if (rd !== e.rdata || er !== e.err) begin
            n_bad++; $display("FAIL tmo_rsp: got %h/%b want %h/%b", rd, er, e.rdata, e.err);
        end
        n_cmp++;
        if (mreq_cnt !== TO) begin n_bad++; $display("FAIL tmo_req_len: got %0d want %0d", mreq_cnt, TO); end
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL tmo_ready: got %b want 1", cmd_ready); end
        stuck_lo = 1'b0;
    endtask

    task automatic test_stuck_high();
        int acc, at, k; logic got, er; logic [DW-1:0] rd; exp_t e;
        issue(1'b0, 8'h44, 8'h00, acc);
        stuck_hi = 1'b1;
        sb.push_back('{8'h00, 1'b1, acc + TO + 3});
        wait_rsp(60, got, at, rd, er);
        e = sb.pop_front();
        n_cmp++;
        if (at !== e.due || rd !== e.rdata || er !== e.err) begin
            n_bad++;
            $display("FAIL stuck_rsp: got @%0d %h/%b want @%0d %h/%b", at, rd, er, e.due, e.rdata, e.err);
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL stuck_hold: got %b want 0", cmd_ready); end
        stuck_hi = 1'b0;
        k = 0;
        while (k < 10 && cmd_ready !== 1'b1) begin
            @(posedge clk); #1; k++;
        end
        n_cmp++;
        if (k !== S + 1) begin n_bad++; $display("FAIL stuck_release: got %0d want %0d", k, S + 1); end
    endtask

    task automatic test_back_to_back();
        int nacc, nrsp, prev, acc; logic bump; exp_t e;
        nacc = 0; nrsp = 0; prev = -1; bump = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20;
        for (int k = 0; k < 80; k++) begin
            if (bump) begin cmd_addr = cmd_addr + 8'h01; bump = 1'b0; end
            if (rsp_valid === 1'b1) begin
                nrsp++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (cyc !== e.due || rsp_rdata !== e.rdata || rsp_error !== e.err) begin
                        n_bad++;
                        $display("FAIL b2b_rsp: got @%0d %h/%b want @%0d %h/%b",
                                 cyc, rsp_rdata, rsp_error, e.due, e.rdata, e.err);
                    end
                end
            end
            if (nacc == 3) begin
                cmd_valid = 1'b0;
            end else if (cmd_ready === 1'b1) begin
                nacc++;
                acc = cyc + 1;
                if (prev >= 0) begin
                    n_cmp++;
                    if (acc - prev !== 2*S + 5) begin
                        n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", acc - prev, 2*S + 5);
                    end
                end
                prev = acc;
                sb.push_back('{ram[cmd_addr], 1'b0, acc + 2*S + 3});
                bump = 1'b1;
            end
            if (nacc == 3 && nrsp == 3) break;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (nacc !== 3 || nrsp !== 3) begin
            n_bad++; $display("FAIL b2b_count: got acc=%0d rsp=%0d want 3/3", nacc, nrsp);
        end
    endtask

    task automatic test_reset_mid();
        int acc, at; logic got, er; logic [DW-1:0] rd; exp_t e;
        issue(1'b0, 8'h40, 8'h00, acc);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got %b want 1", mem_req); end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, mem_write, rsp_valid, cmd_ready} !== 4'b0) begin
            n_bad++; $display("FAIL rstmid_async: got %b want 0000", {mem_req, mem_write, rsp_valid, cmd_ready});
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_rsp(12, got, at, rd, er);
        n_cmp++;
        if (got !== 1'b0) begin n_bad++; $display("FAIL rstmid_norsp: got rsp@%0d want none", at); end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready); end
        issue(1'b0, 8'h41, 8'h00, acc);
        sb.push_back('{ram[8'h41], 1'b0, acc + 2*S + 3});
        wait_rsp(40, got, at, rd, er);
        e = sb.pop_front();
        n_cmp++;
        if (at !== e.due || rd !== e.rdata || er !== e.err) begin
            n_bad++;
            $display("FAIL rstmid_read: got @%0d %h/%b want @%0d %h/%b", at, rd, er, e.due, e.rdata, e.err);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
        ram[8'h12] = 8'hA5;
        ram[8'h33] = 8'hEE;
        ram[8'h44] = 8'h99;
        test_reset();
        test_read();
        test_write_read();
        test_timeout_low();
        test_stuck_high();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
